// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: opcode map, legality check,
// and default widths.
// Build option: ALU_ARB_FIXED_PRIO_EN (see alu_share_arbiter.sv).
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 4;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 4'b0010;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 4'b0011;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 4'b0100;
    localparam logic [ALU_OP_W-1:0] OP_SLL  = 4'b0101;
    localparam logic [ALU_OP_W-1:0] OP_SLT  = 4'b0111;
    localparam logic [ALU_OP_W-1:0] OP_SRL  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] OP_SRA  = 4'b1001;
    localparam logic [ALU_OP_W-1:0] OP_PASS = 4'b1111;

    // Opcodes outside this set are still accepted but flagged as errors.
    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SLL, OP_SLT, OP_SRL, OP_SRA, OP_PASS: is_legal_op = 1'b1;
            default:                                 is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_resp_slot.sv
// One-deep response register with valid/ready handshake on the consumer side.
// A load in the same cycle as a consume refills the slot (no bubble).
module alu_resp_slot
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic              zero_i,
    input  logic              err_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              err_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;

    // Next slot contents: refill wins over drain; otherwise hold.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        if (load_i) begin
            valid_d  = 1'b1;
            result_d = result_i;
            zero_d   = zero_i;
            err_d    = err_i;
        end else if (valid_q && ready_i) begin
            valid_d  = 1'b0;
        end
    end

    // Slot storage, dropped on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign err_o    = err_q;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters with a
// round-robin, work-conserving grant and a one-deep response slot per port.
// Build option: ALU_ARB_FIXED_PRIO_EN -- when defined, port 0 always wins a
// tie and the round-robin pointer is removed (port 1 may starve).
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,

    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    output logic              resp0_zero,
    output logic              resp0_err,

    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic              resp1_zero,
    output logic              resp1_err,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    logic elig0, elig1;
    logic gnt0, gnt1;

    logic              op_legal;
    logic [DATA_W-1:0] cap_result;
    logic              cap_zero;
    logic              cap_err;

    // A port may issue when its slot is empty or is being drained this cycle.
    assign elig0 = req0_valid && (!resp0_valid || resp0_ready);
    assign elig1 = req1_valid && (!resp1_valid || resp1_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: port 0 takes every tie.
    always_comb begin
        gnt0 = elig0;
        gnt1 = elig1 && !elig0;
    end
`else
    logic last_grant_q, last_grant_d;

    // Round-robin: on a tie the port that did not win last time is granted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (elig0 && elig1) begin
            if (last_grant_q) gnt0 = 1'b1;
            else              gnt1 = 1'b1;
        end else begin
            gnt0 = elig0;
            gnt1 = elig1;
        end
    end

    // Pointer follows the winner and holds through idle cycles.
    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt0)      last_grant_d = 1'b0;
        else if (gnt1) last_grant_d = 1'b1;
    end

    // Pointer resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_grant_q <= 1'b1;
        else     last_grant_q <= last_grant_d;
    end
`endif

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Operand mux: port 1 only when it holds the grant; idle shows port 0.
    always_comb begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        alu_op = req0_op;
        if (gnt1) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end
    end

    // Illegal opcodes are captured as result 0 / zero 1 / err 1.
    always_comb begin
        op_legal   = is_legal_op(alu_op);
        cap_result = op_legal ? alu_result : '0;
        cap_zero   = op_legal ? alu_zero : 1'b1;
        cap_err    = !op_legal;
    end

    alu_resp_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk      (clk),
        .rst      (rst),
        .load_i   (gnt0),
        .result_i (cap_result),
        .zero_i   (cap_zero),
        .err_i    (cap_err),
        .ready_i  (resp0_ready),
        .valid_o  (resp0_valid),
        .result_o (resp0_result),
        .zero_o   (resp0_zero),
        .err_o    (resp0_err)
    );

    alu_resp_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk      (clk),
        .rst      (rst),
        .load_i   (gnt1),
        .result_i (cap_result),
        .zero_i   (cap_zero),
        .err_i    (cap_err),
        .ready_i  (resp1_ready),
        .valid_o  (resp1_valid),
        .result_o (resp1_result),
        .zero_o   (resp1_zero),
        .err_o    (resp1_err)
    );

endmodule
